// File: rtl/seq_multiplier_if.sv
// Handshake bundle for seq_multiplier.
//   slave  modport: the multiplier (consumes operands, produces the product)
//   master modport: the surrounding datapath (supplies operands, takes the product)
// Signals:
//   in_valid/in_ready   operand handshake; in_signed selects two's-complement mode
//   a0 [A0_WIDTH]       multiplicand
//   a1 [A1_WIDTH]       multiplier
//   out_valid/out_ready product handshake
//   product [A0_WIDTH+A1_WIDTH]
//   busy                multiplier is working or holding a result
interface seq_multiplier_if #(
  parameter int unsigned A0_WIDTH = 8,
  parameter int unsigned A1_WIDTH = 8
);
  localparam int unsigned PRODUCT_WIDTH = A0_WIDTH + A1_WIDTH;

  logic                     in_valid;
  logic                     in_ready;
  logic                     in_signed;
  logic [A0_WIDTH-1:0]      a0;
  logic [A1_WIDTH-1:0]      a1;
  logic                     out_valid;
  logic                     out_ready;
  logic [PRODUCT_WIDTH-1:0] product;
  logic                     busy;

  modport slave (
    input  in_valid,
    input  in_signed,
    input  a0,
    input  a1,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product,
    output busy
  );

  modport master (
    output in_valid,
    output in_signed,
    output a0,
    output a1,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product,
    input  busy
  );
endinterface

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with valid/ready handshakes.
//
// One A0_WIDTH+1-bit adder is reused over A1_WIDTH iterations. Signed operands
// are converted to unsigned magnitudes on accept; the sign is reapplied to the
// final sum, so the core loop is always unsigned.
//
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous reset, active-high; aborts any transaction in flight
//   bus  seq_multiplier_if.slave (operand handshake, product handshake, busy)
//
// Optional build macro:
//   SEQ_MUL_EARLY_TERM_EN  stop iterating once no set multiplier bits remain;
//                          the partial sum is then realigned by the number of
//                          skipped iterations. Products are unchanged.
module seq_multiplier #(
  parameter int unsigned A0_WIDTH = 8,
  parameter int unsigned A1_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  seq_multiplier_if.slave bus
);

  localparam int unsigned PRODUCT_WIDTH = A0_WIDTH + A1_WIDTH;
  localparam int unsigned CntW          = $clog2(A1_WIDTH + 1);
  localparam logic [CntW-1:0] LastCount = CntW'(A1_WIDTH);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e                   state_q;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic                     busy_q;
  logic [PRODUCT_WIDTH-1:0] product_q;

  logic                     sign_flag_q;
  logic [A0_WIDTH-1:0]      mcand_q;
  logic [A1_WIDTH-1:0]      mplier_q;
  logic [A0_WIDTH-1:0]      acc_q;
  logic [CntW-1:0]          count_q;
`ifdef SEQ_MUL_EARLY_TERM_EN
  // Multiplier bits not yet consumed; zero means the remaining adds are no-ops.
  logic [A1_WIDTH-1:0]      rem_q;
  logic [A1_WIDTH-1:0]      rem_d;
  logic [CntW-1:0]          shamt;
`endif

  // Accept-time operand conditioning.
  logic                     sign_in;
  logic [A0_WIDTH-1:0]      a0_mag;
  logic [A1_WIDTH-1:0]      a1_mag;

  // One iteration of the datapath.
  logic [A0_WIDTH:0]        addend;
  logic [A0_WIDTH:0]        sum;
  logic [A0_WIDTH-1:0]      acc_d;
  logic [A1_WIDTH-1:0]      mplier_d;
  logic [CntW-1:0]          count_d;
  logic                     last_iter;
  logic [PRODUCT_WIDTH-1:0] full_d;
  logic [PRODUCT_WIDTH-1:0] aligned;
  logic [PRODUCT_WIDTH-1:0] result_d;

  always_comb begin
    sign_in = bus.in_signed & (bus.a0[A0_WIDTH-1] ^ bus.a1[A1_WIDTH-1]);
    // Magnitudes are unsigned at full width, so the most negative value maps
    // to 2^(W-1) without overflow.
    a0_mag  = (bus.in_signed && bus.a0[A0_WIDTH-1]) ? (~bus.a0 + 1'b1) : bus.a0;
    a1_mag  = (bus.in_signed && bus.a1[A1_WIDTH-1]) ? (~bus.a1 + 1'b1) : bus.a1;
  end

  always_comb begin
    addend   = mplier_q[0] ? {1'b0, mcand_q} : '0;
    sum      = {1'b0, acc_q} + addend;
    // {sum, mplier} shifted right by one: the carry lands in the acc MSB and
    // the sum LSB becomes a settled low product bit at the mplier MSB.
    acc_d    = sum[A0_WIDTH:1];
    mplier_d = {sum[0], mplier_q[A1_WIDTH-1:1]};
    count_d  = count_q + 1'b1;
    full_d   = {acc_d, mplier_d};
`ifdef SEQ_MUL_EARLY_TERM_EN
    rem_d     = rem_q >> 1;
    last_iter = (rem_d == '0) || (count_d == LastCount);
    // Skipped iterations would only have shifted; apply them in one step.
    shamt     = LastCount - count_d;
    aligned   = full_d >> shamt;
`else
    last_iter = (count_d == LastCount);
    aligned   = full_d;
`endif
    result_d = sign_flag_q ? (~aligned + 1'b1) : aligned;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      product_q   <= '0;
      sign_flag_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
`ifdef SEQ_MUL_EARLY_TERM_EN
      rem_q       <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          // in_ready is high throughout IDLE, so in_valid alone completes the handshake.
          if (bus.in_valid) begin
            sign_flag_q <= sign_in;
            mcand_q     <= a0_mag;
            mplier_q    <= a1_mag;
            acc_q       <= '0;
            count_q     <= '0;
`ifdef SEQ_MUL_EARLY_TERM_EN
            rem_q       <= a1_mag;
`endif
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StBusy;
          end
        end
        StBusy: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          count_q  <= count_d;
`ifdef SEQ_MUL_EARLY_TERM_EN
          rem_q    <= rem_d;
`endif
          if (last_iter) begin
            product_q   <= result_d;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          // Leaving DONE never accepts: in_ready was low on this edge.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign bus.busy      = busy_q;

endmodule
